// File: rtl/cpu_ctrl_pkg.sv
// Shared definitions for the pipeline control slice.
// Holds the MIPS exception codes, the hazard scheduler FSM encoding and the
// default multi-cycle unit latencies.
package cpu_ctrl_pkg;

    localparam logic [4:0] EXC_INT  = 5'd0;
    localparam logic [4:0] EXC_ADEL = 5'd4;
    localparam logic [4:0] EXC_ADES = 5'd5;
    localparam logic [4:0] EXC_RI   = 5'd10;
    localparam logic [4:0] EXC_OV   = 5'd12;

    localparam int MUL_LAT_DEF = 5;
    localparam int DIV_LAT_DEF = 10;
    localparam int CNT_W_DEF   = 4;

    typedef enum logic [1:0] {
        ST_RUN        = 2'd0,
        ST_EXC_REDIR  = 2'd1,
        ST_ERET_REDIR = 2'd2
    } sched_state_t;

endpackage

// File: rtl/md_busy_cnt.sv
// Loadable down-counter tracking HI/LO occupancy after a mult/div issues.
// Ports:
//   clk, reset  : clock, async active-high reset
//   load        : load load_val this edge (wins over decrement)
//   load_val    : cycles the unit stays busy
//   busy        : counter non-zero
module md_busy_cnt #(
    parameter int CNT_W = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             load,
    input  logic [CNT_W-1:0] load_val,
    output logic             busy
);

    logic [CNT_W-1:0] md_cnt_q;
    logic [CNT_W-1:0] md_cnt_d;

    always_comb begin
        md_cnt_d = md_cnt_q;
        if (load) begin
            md_cnt_d = load_val;
        end else if (md_cnt_q != '0) begin
            md_cnt_d = md_cnt_q - 1'b1;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            md_cnt_q <= '0;
        end else begin
            md_cnt_q <= md_cnt_d;
        end
    end

    assign busy = (md_cnt_q != '0);

endmodule

// File: rtl/pipe_hazard_sched.sv
// Stall / flush / redirect sequencer for the 5-stage MIPS pipeline.
// Exceptions and interrupts are taken precisely at M; the cycle after the
// flush redirects the PC to the handler vector (exception) or EPC (ERET).
// Ports:
//   inputs  : load_use_d, md_use_d, md_start_e, md_is_div_e, exp_valid_m,
//             exp_m, eret_m, int_req, exl
//   outputs : stall_f/stall_d (hold PC, F/D), flush_d/e/m (clear F/D, D/E,
//             E/M), epc_we + exc_code (CP0 capture), pc_redirect(+_sel),
//             md_busy (HI/LO not ready)
//
// state         | meaning
// ST_RUN        | normal issue; hazards and exceptions resolved here
// ST_EXC_REDIR  | pipe flushed, PC takes the exception vector
// ST_ERET_REDIR | pipe flushed, PC takes EPC
module pipe_hazard_sched
    import cpu_ctrl_pkg::*;
#(
    parameter int MUL_LAT = MUL_LAT_DEF,
    parameter int DIV_LAT = DIV_LAT_DEF,
    parameter int CNT_W   = CNT_W_DEF
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       load_use_d,
    input  logic       md_use_d,
    input  logic       md_start_e,
    input  logic       md_is_div_e,
    input  logic       exp_valid_m,
    input  logic [4:0] exp_m,
    input  logic       eret_m,
    input  logic       int_req,
    input  logic       exl,
    output logic       stall_f,
    output logic       stall_d,
    output logic       flush_d,
    output logic       flush_e,
    output logic       flush_m,
    output logic       epc_we,
    output logic [4:0] exc_code,
    output logic       pc_redirect,
    output logic       pc_redirect_sel,
    output logic       md_busy
);

    sched_state_t state_q, state_d;
    logic         int_pending_q, int_pending_d;
    logic         take_int, take_exc;
    logic         md_load;
    logic [CNT_W-1:0] md_load_val;
    logic         cnt_busy;

    assign take_int = int_pending_q & ~exl;
    assign take_exc = exp_valid_m | take_int;

    // A mult/div in E that is being flushed never reaches the unit.
    assign md_load     = (state_q == ST_RUN) & md_start_e & ~take_exc & ~eret_m;
    assign md_load_val = md_is_div_e ? CNT_W'(DIV_LAT) : CNT_W'(MUL_LAT);

    md_busy_cnt #(.CNT_W(CNT_W)) u_md_busy_cnt (
        .clk      (clk),
        .reset    (reset),
        .load     (md_load),
        .load_val (md_load_val),
        .busy     (cnt_busy)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q       <= ST_RUN;
            int_pending_q <= 1'b0;
        end else begin
            state_q       <= state_d;
            int_pending_q <= int_pending_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_RUN: begin
                if (take_exc) begin
                    state_d = ST_EXC_REDIR;
                end else if (eret_m) begin
                    state_d = ST_ERET_REDIR;
                end
            end
            ST_EXC_REDIR:  state_d = ST_RUN;
            ST_ERET_REDIR: state_d = ST_RUN;
            default:       state_d = ST_RUN;
        endcase
    end

    // Interrupt is consumed only when it, not an internal exception, caused
    // the flush; a still-asserted request re-arms it.
    always_comb begin
        int_pending_d = int_pending_q;
        if ((state_q == ST_RUN) && take_int && !exp_valid_m) begin
            int_pending_d = 1'b0;
        end
        if (int_req) begin
            int_pending_d = 1'b1;
        end
    end

    always_comb begin
        stall_f         = 1'b0;
        stall_d         = 1'b0;
        flush_d         = 1'b0;
        flush_e         = 1'b0;
        flush_m         = 1'b0;
        epc_we          = 1'b0;
        exc_code        = 5'd0;
        pc_redirect     = 1'b0;
        pc_redirect_sel = 1'b0;
        md_busy         = 1'b0;
        if (!reset) begin
            md_busy = cnt_busy;
            case (state_q)
                ST_RUN: begin
                    if (take_exc) begin
                        flush_d  = 1'b1;
                        flush_e  = 1'b1;
                        flush_m  = 1'b1;
                        epc_we   = 1'b1;
                        exc_code = exp_valid_m ? exp_m : EXC_INT;
                    end else if (eret_m) begin
                        flush_d = 1'b1;
                        flush_e = 1'b1;
                        flush_m = 1'b1;
                    end else if ((cnt_busy && md_use_d) || load_use_d) begin
                        stall_f = 1'b1;
                        stall_d = 1'b1;
                        flush_e = 1'b1;
                    end
                end
                ST_EXC_REDIR: begin
                    pc_redirect = 1'b1;
                    flush_d     = 1'b1;
                end
                ST_ERET_REDIR: begin
                    pc_redirect     = 1'b1;
                    pc_redirect_sel = 1'b1;
                    flush_d         = 1'b1;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_pipe_hazard_sched.sv
module tb_pipe_hazard_sched;

    localparam int MUL_LAT = 5;
    localparam int DIV_LAT = 10;

    logic       clk = 1'b0;
    logic       reset;
    logic       load_use_d, md_use_d, md_start_e, md_is_div_e;
    logic       exp_valid_m, eret_m, int_req, exl;
    logic [4:0] exp_m;
    logic       stall_f, stall_d, flush_d, flush_e, flush_m, epc_we;
    logic [4:0] exc_code;
    logic       pc_redirect, pc_redirect_sel, md_busy;

    int n_checks = 0;
    int n_err    = 0;

    pipe_hazard_sched #(.MUL_LAT(MUL_LAT), .DIV_LAT(DIV_LAT), .CNT_W(4)) dut (
        .clk             (clk),
        .reset           (reset),
        .load_use_d      (load_use_d),
        .md_use_d        (md_use_d),
        .md_start_e      (md_start_e),
        .md_is_div_e     (md_is_div_e),
        .exp_valid_m     (exp_valid_m),
        .exp_m           (exp_m),
        .eret_m          (eret_m),
        .int_req         (int_req),
        .exl             (exl),
        .stall_f         (stall_f),
        .stall_d         (stall_d),
        .flush_d         (flush_d),
        .flush_e         (flush_e),
        .flush_m         (flush_m),
        .epc_we          (epc_we),
        .exc_code        (exc_code),
        .pc_redirect     (pc_redirect),
        .pc_redirect_sel (pc_redirect_sel),
        .md_busy         (md_busy)
    );

    always #5 clk = ~clk;

    // {stall_f, stall_d, flush_d, flush_e, flush_m, epc_we, exc_code, pc_redirect, pc_redirect_sel, md_busy}
    logic [13:0] out_vec;
    assign out_vec = {stall_f, stall_d, flush_d, flush_e, flush_m, epc_we, exc_code,
                      pc_redirect, pc_redirect_sel, md_busy};

    typedef struct {
        logic        rst, lu, mu, ms, mdiv, ev;
        logic [4:0]  ec;
        logic        er, ir, xl;
        logic [13:0] exp;
    } vec_t;

    function automatic logic [13:0] outv(logic sf, logic sd, logic fd, logic fe, logic fm,
                                         logic we, logic [4:0] code, logic pr, logic ps, logic mb);
        return {sf, sd, fd, fe, fm, we, code, pr, ps, mb};
    endfunction

    function automatic vec_t mk(logic rst, logic lu, logic mu, logic ms, logic mdiv, logic ev,
                                logic [4:0] ec, logic er, logic ir, logic xl, logic [13:0] e);
        vec_t v;
        v.rst = rst; v.lu = lu; v.mu = mu; v.ms = ms; v.mdiv = mdiv; v.ev = ev;
        v.ec = ec; v.er = er; v.ir = ir; v.xl = xl; v.exp = e;
        return v;
    endfunction

    task automatic apply_in(vec_t v);
        reset       = v.rst;
        load_use_d  = v.lu;
        md_use_d    = v.mu;
        md_start_e  = v.ms;
        md_is_div_e = v.mdiv;
        exp_valid_m = v.ev;
        exp_m       = v.ec;
        eret_m      = v.er;
        int_req     = v.ir;
        exl         = v.xl;
    endtask

    task automatic check_vec(string name, logic [13:0] got, logic [13:0] want);
        n_checks++;
        if (got !== want) begin
            n_err++;
            $display("FAIL %s: got %b required %b", name, got, want);
        end
    endtask

    task automatic check_int(string name, int got, int want);
        n_checks++;
        if (got != want) begin
            n_err++;
            $display("FAIL %s: got %0d required %0d", name, got, want);
        end
    endtask

    // Inputs change 1 time unit after a rising edge; outputs sampled 1 unit later.
    task automatic step_check(string name, logic [13:0] want);
        #1;
        check_vec(name, out_vec, want);
        @(posedge clk);
        #1;
    endtask

    // Reference model: redirect owed next cycle, interrupt latch, and the
    // edge count at which the mult/div result becomes available.
    int     m_redir;      // 0 none, 1 handler vector, 2 EPC
    bit     m_int_pend;
    longint m_edges, m_busy_end;

    function automatic logic [13:0] model_out(vec_t v);
        logic        busy;
        logic [13:0] r;
        busy = (m_edges < m_busy_end);
        if (v.rst) return '0;
        if (m_redir == 1)      r = outv(0,0,1,0,0,0,5'd0,1,0,0);
        else if (m_redir == 2) r = outv(0,0,1,0,0,0,5'd0,1,1,0);
        else if (v.ev || (m_int_pend && !v.xl))
            r = outv(0,0,1,1,1,1, v.ev ? v.ec : 5'd0, 0,0,0);
        else if (v.er)         r = outv(0,0,1,1,1,0,5'd0,0,0,0);
        else if ((busy && v.mu) || v.lu) r = outv(1,1,0,1,0,0,5'd0,0,0,0);
        else                   r = '0;
        r[0] = busy;
        return r;
    endfunction

    task automatic model_step(vec_t v);
        bit consume;
        consume = 1'b0;
        if (v.rst) begin
            m_redir = 0; m_int_pend = 1'b0; m_busy_end = 0; m_edges = 0;
            return;
        end
        if (m_redir != 0) begin
            m_redir = 0;
        end else if (v.ev || (m_int_pend && !v.xl)) begin
            m_redir = 1;
            consume = !v.ev;
        end else if (v.er) begin
            m_redir = 2;
        end else if (v.ms) begin
            m_busy_end = m_edges + 1 + (v.mdiv ? DIV_LAT : MUL_LAT);
        end
        if (v.ir) m_int_pend = 1'b1;
        else if (consume) m_int_pend = 1'b0;
        m_edges++;
    endtask

    vec_t tbl[$];
    vec_t idle;

    initial begin
        logic [13:0] LU, ERETF, RED_H, RED_E, STALL_MD;
        int cnt;
        LU       = outv(1,1,0,1,0,0,5'd0,0,0,0);
        ERETF    = outv(0,0,1,1,1,0,5'd0,0,0,0);
        RED_H    = outv(0,0,1,0,0,0,5'd0,1,0,0);
        RED_E    = outv(0,0,1,0,0,0,5'd0,1,1,0);
        STALL_MD = outv(1,1,0,1,0,0,5'd0,0,0,1);
        idle = mk(0,0,0,0,0,0,5'd0,0,0,0,'0);

        //          rst lu mu ms dv ev ec   er ir xl expected
        tbl.push_back(mk(1,0,0,0,0,0,5'd0, 0,0,0, '0));
        tbl.push_back(mk(1,1,1,0,0,1,5'd12,1,0,0, '0));
        tbl.push_back(mk(0,0,0,0,0,0,5'd0, 0,0,0, '0));
        tbl.push_back(mk(0,1,0,0,0,0,5'd0, 0,0,0, LU));
        tbl.push_back(mk(0,0,0,0,0,0,5'd0, 0,0,0, '0));
        tbl.push_back(mk(0,1,0,1,0,1,5'd12,0,0,0, outv(0,0,1,1,1,1,5'd12,0,0,0)));
        tbl.push_back(mk(0,1,1,0,0,0,5'd0, 0,0,0, RED_H));
        tbl.push_back(mk(0,0,0,0,0,0,5'd0, 0,0,0, '0));
        tbl.push_back(mk(0,0,0,0,0,0,5'd0, 0,1,1, '0));
        tbl.push_back(mk(0,0,0,0,0,0,5'd0, 0,0,1, '0));
        tbl.push_back(mk(0,0,0,0,0,0,5'd0, 0,0,1, '0));
        tbl.push_back(mk(0,0,0,0,0,0,5'd0, 0,0,0, outv(0,0,1,1,1,1,5'd0,0,0,0)));
        tbl.push_back(mk(0,0,0,0,0,0,5'd0, 0,0,0, RED_H));
        tbl.push_back(mk(0,0,0,0,0,0,5'd0, 0,0,0, '0));
        tbl.push_back(mk(0,0,0,0,0,0,5'd0, 0,0,0, '0));
        tbl.push_back(mk(0,0,0,0,0,0,5'd0, 1,0,0, ERETF));
        tbl.push_back(mk(0,1,0,0,0,1,5'd10,1,0,0, RED_E));
        tbl.push_back(mk(0,0,0,0,0,0,5'd0, 0,0,0, '0));
        tbl.push_back(mk(0,0,0,0,0,0,5'd0, 0,1,0, '0));
        tbl.push_back(mk(0,0,0,0,0,1,5'd4, 0,0,0, outv(0,0,1,1,1,1,5'd4,0,0,0)));
        tbl.push_back(mk(0,0,0,0,0,0,5'd0, 0,0,0, RED_H));
        tbl.push_back(mk(0,0,0,0,0,0,5'd0, 0,0,0, outv(0,0,1,1,1,1,5'd0,0,0,0)));
        tbl.push_back(mk(0,0,0,0,0,0,5'd0, 0,0,0, RED_H));
        tbl.push_back(mk(0,0,0,0,0,0,5'd0, 0,0,0, '0));

        apply_in(tbl[0]);
        #1;
        for (int i = 0; i < tbl.size(); i++) begin
            apply_in(tbl[i]);
            step_check($sformatf("tbl%0d", i), tbl[i].exp);
        end

        // mult then dependent md_use_d: stall for exactly the latency
        for (int pass = 0; pass < 2; pass++) begin
            vec_t v;
            v = idle; v.ms = 1'b1; v.mdiv = (pass == 1);
            apply_in(v);
            step_check(pass == 0 ? "mul_issue" : "div_issue", '0);
            v = idle; v.mu = 1'b1;
            apply_in(v);
            cnt = 0;
            for (int k = 0; k < 30; k++) begin
                #1;
                if (!md_busy) break;
                check_vec("md_stall", out_vec, STALL_MD);
                cnt++;
                @(posedge clk);
                #1;
            end
            check_int(pass == 0 ? "mul_busy_len" : "div_busy_len", cnt,
                      pass == 0 ? MUL_LAT : DIV_LAT);
            check_vec("md_release", out_vec, '0);
            @(posedge clk);
            #1;
        end

        // div in flight, then reset mid-count
        begin
            vec_t v;
            v = idle; v.ms = 1'b1; v.mdiv = 1'b1;
            apply_in(v);
            step_check("rst_div_issue", '0);
            apply_in(idle);
            for (int k = 0; k < 3; k++) step_check("rst_div_busy", outv(0,0,0,0,0,0,5'd0,0,0,1));
            v = idle; v.rst = 1'b1; v.mu = 1'b1; v.lu = 1'b1;
            apply_in(v);
            step_check("rst_forces_zero", '0);
            v = idle; v.mu = 1'b1;
            apply_in(v);
            step_check("rst_after_release", '0);
        end

        // randomized run against the reference model
        begin
            vec_t v;
            v = idle; v.rst = 1'b1;
            apply_in(v);
            step_check("rand_rst", '0);
            model_step(v);
            for (int i = 0; i < 600; i++) begin
                v.rst  = ($urandom_range(0, 79) == 0);
                v.lu   = ($urandom_range(0, 5) == 0);
                v.mu   = ($urandom_range(0, 2) == 0);
                v.ms   = ($urandom_range(0, 5) == 0);
                v.mdiv = $urandom_range(0, 1);
                v.ev   = ($urandom_range(0, 11) == 0);
                v.ec   = 5'($urandom_range(0, 31));
                v.er   = ($urandom_range(0, 13) == 0);
                v.ir   = ($urandom_range(0, 9) == 0);
                v.xl   = ($urandom_range(0, 2) == 0);
                v.exp  = model_out(v);
                apply_in(v);
                step_check($sformatf("rand%0d", i), v.exp);
                model_step(v);
            end
        end

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule
